// File: rtl/nios_mul_pkg.sv
// Shared definitions for the nios_mul multiplier: op encoding and its type.
package nios_mul_pkg;

  typedef logic [1:0] mul_op_t;

  localparam mul_op_t MUL_OP_LO  = 2'b00;
  localparam mul_op_t MUL_OP_XUU = 2'b01;
  localparam mul_op_t MUL_OP_XSU = 2'b10;
  localparam mul_op_t MUL_OP_XSS = 2'b11;

endpackage

// File: rtl/nios_mul_slice.sv
// Registered unsigned SxS multiplier with load enable and synchronous clear.
module nios_mul_slice #(
  parameter int S = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           en,
  input  logic [S-1:0]   a,
  input  logic [S-1:0]   b,
  output logic [2*S-1:0] p
);

  logic [2*S-1:0] p_d;
  logic [2*S-1:0] p_q;

  always_comb begin
    p_d = p_q;
    if (en) p_d = a * b;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) p_q <= '0;
    else          p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/nios_mul_unit.sv
// Two-stage pipelined WIDTH x WIDTH multiplier returning the low or high half
// of the product, with valid/ready handshake and a pass-through tag.
module nios_mul_unit
  import nios_mul_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int S = WIDTH / 2;

  logic adv;

  logic             v1_d, v1_q;
  mul_op_t          op1_d, op1_q;
  logic [TAG_W-1:0] tag1_d, tag1_q;
  logic [WIDTH-1:0] a1_d, a1_q, b1_d, b1_q;
  logic             sa1_d, sa1_q, sb1_d, sb1_q;

  logic [WIDTH-1:0] p_ll, p_lh, p_hl, p_hh;

  logic [2*WIDTH-1:0] u;
  logic [WIDTH-1:0]   h;
  logic [WIDTH-1:0]   res;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] out_result_d, out_result_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;

  // A full output register blocks the whole pipe, so both stages share one enable.
  assign adv      = ~out_valid_q | out_ready;
  assign in_ready = adv & reset_n;

  nios_mul_slice #(.S(S)) u_ll (.clk(clk), .reset_n(reset_n), .en(adv),
    .a(in_a[S-1:0]), .b(in_b[S-1:0]), .p(p_ll));
  nios_mul_slice #(.S(S)) u_lh (.clk(clk), .reset_n(reset_n), .en(adv),
    .a(in_a[S-1:0]), .b(in_b[WIDTH-1:S]), .p(p_lh));
  nios_mul_slice #(.S(S)) u_hl (.clk(clk), .reset_n(reset_n), .en(adv),
    .a(in_a[WIDTH-1:S]), .b(in_b[S-1:0]), .p(p_hl));
  nios_mul_slice #(.S(S)) u_hh (.clk(clk), .reset_n(reset_n), .en(adv),
    .a(in_a[WIDTH-1:S]), .b(in_b[WIDTH-1:S]), .p(p_hh));

  always_comb begin
    v1_d   = v1_q;
    op1_d  = op1_q;
    tag1_d = tag1_q;
    a1_d   = a1_q;
    b1_d   = b1_q;
    sa1_d  = sa1_q;
    sb1_d  = sb1_q;
    if (adv) begin
      v1_d   = in_valid & in_ready;
      op1_d  = in_op;
      tag1_d = in_tag;
      a1_d   = in_a;
      b1_d   = in_b;
      sa1_d  = in_a[WIDTH-1];
      sb1_d  = in_b[WIDTH-1];
    end
  end

  // High-half sign correction: subtract the other operand for each negative one.
  always_comb begin
    u = {p_hh, p_ll}
      + {{S{1'b0}}, p_lh, {S{1'b0}}}
      + {{S{1'b0}}, p_hl, {S{1'b0}}};
    h = u[2*WIDTH-1:WIDTH];
    case (op1_q)
      MUL_OP_XUU: res = h;
      MUL_OP_XSU: res = h - (sa1_q ? b1_q : {WIDTH{1'b0}});
      MUL_OP_XSS: res = h - (sa1_q ? b1_q : {WIDTH{1'b0}})
                          - (sb1_q ? a1_q : {WIDTH{1'b0}});
      default:    res = u[WIDTH-1:0];
    endcase
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    if (adv) begin
      out_valid_d  = v1_q;
      out_result_d = res;
      out_tag_d    = tag1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v1_q         <= 1'b0;
      op1_q        <= MUL_OP_LO;
      tag1_q       <= '0;
      a1_q         <= '0;
      b1_q         <= '0;
      sa1_q        <= 1'b0;
      sb1_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_tag_q    <= '0;
    end else begin
      v1_q         <= v1_d;
      op1_q        <= op1_d;
      tag1_q       <= tag1_d;
      a1_q         <= a1_d;
      b1_q         <= b1_d;
      sa1_q        <= sa1_d;
      sb1_q        <= sb1_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

endmodule

// File: doc/nios_mul_unit.md
# nios_mul_unit

Parametrised, pipelined integer multiplier for the Nios II-class CPU datapath. It is the successor to the three-partial-product multiply cell and produces either the low or the high half of the full 2·WIDTH product. It supports unsigned, signed×unsigned and signed×signed high-half modes, a valid/ready handshake with backpressure, and a destination tag carried alongside each operation. It sits between the E-stage operand muxes and the M-stage writeback mux.

## Interface
- WIDTH, 32: operand and result width; must be even and ≥ 8.
- TAG_W, 5: width of the pass-through tag (destination register index).
- clk  in  1  clock; all logic rising-edge.
- reset_n  in  1  reset; **synchronous, active-low**.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts an operation this cycle.
- in_op  in  2  mode: 00 MUL (low half), 01 MULXUU (high, u×u), 10 MULXSU (high, a signed, b unsigned), 11 MULXSS (high, s×s).
- in_a  in  WIDTH  operand a.
- in_b  in  WIDTH  operand b.
- in_tag  in  TAG_W  returned unchanged with the result.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  WIDTH  selected product half.
- out_tag  out  TAG_W  tag of this result.

## Operation
- S = WIDTH/2. Each operand is split into halves: aL, aH, bL, bH.
- Stage 1 (P1) registers four unsigned S×S partial products: pLL = aL·bL, pLH = aL·bH, pHL = aH·bL, pHH = aH·bH. It also registers op, tag, the sign bits a[WIDTH-1] and b[WIDTH-1], and the full in_a and in_b needed for sign correction.
- Stage 2 (P2) forms the unsigned product U = pLL + (pLH << S) + (pHL << S) + (pHH << WIDTH), computed mod 2^(2·WIDTH).
- Sign correction is applied to the high half H = U[2W-1:W], mod 2^W:
  - MULXSS: H − (a<0 ? b : 0) − (b<0 ? a : 0).
  - MULXSU: H − (a<0 ? b : 0).
  - MULXUU: H unchanged.
- MUL returns U[W-1:0], which is sign-independent.
- The P2 output register drives out_result and out_tag.
- Pipeline advance: adv = ~out_valid | out_ready. Both stages load only when adv = 1.
- in_ready = adv, combinational.
- An operation is accepted when in_valid & in_ready.
- Valid bits: v1 ← in_valid & in_ready on adv. out_valid ← v1 on adv.
- When adv = 0, every register holds, including the P1 partial products. Stage-1 data is never overwritten while stalled.
- Reset (reset_n = 0 at a clk edge) clears v1, out_valid, out_result, out_tag and all P1 registers to 0. This applies mid-operation: in-flight operations are discarded and no result emerges for them.
- in_ready is low during reset. After reset it is 1 because out_valid = 0.

## Timing
- Latency: an operation accepted at edge n appears with out_valid = 1 after edge n+2, given no stall.
- Throughput: one operation per cycle while out_ready = 1.
- Stall: while out_valid & ~out_ready, out_result and out_tag are held stable and in_ready = 0. Up to 2 operations (P1 and P2) are buffered.
- out_ready is permitted to be 1 while out_valid = 0; this has no effect beyond keeping adv = 1.
- Results are strictly in acceptance order.
- Reset values: out_valid 0, out_result 0, out_tag 0. in_ready follows the combinational rule.
- No combinational path from in_* to out_*. The only combinational path is out_ready → in_ready.

## Structure
- Shared package nios_mul_pkg holds:
  - the op encoding constants MUL_OP_LO, MUL_OP_XUU, MUL_OP_XSU, MUL_OP_XSS;
  - a typedef for the 2-bit op.
- Sub-module nios_mul_slice: registered unsigned S×S multiplier with enable and synchronous clear, instantiated four times in P1 so that it maps to DSP blocks.
- Top level contains the handshake, sideband registers, the P2 adder tree, sign correction and the half select.

## Test plan
- Reset, then all four modes with a = b = 0xFFFFFFFF, WIDTH = 32, out_ready = 1. Required results in order, each 2 cycles after issue:
  - MUL → 0x00000001
  - MULXUU → 0xFFFFFFFE
  - MULXSU → 0xFFFFFFFF
  - MULXSS → 0x00000000
- a = b = 0x80000000 with MULXSS and with MULXUU → 0x40000000 for both. a = b = 0x00010000 with MUL → 0x00000000, with MULXUU → 0x00000001.
- Issue three back-to-back operations with tags 1, 2, 3 while out_ready = 0. Required:
  - in_ready drops after two operations are accepted; the third is held off.
  - out_result and out_tag stay stable for the whole stall.
  - On raising out_ready, tags 1, 2, 3 emerge on consecutive cycles with correct products.
- Assert reset_n = 0 for one cycle while two operations are in flight. Required: out_valid = 0 and out_result = 0 the next cycle, and no stale result ever appears.
- Random regression, 10k operations, with random in_valid and out_ready. Compare against a 2·WIDTH-bit signed/unsigned reference model for WIDTH = 32 and WIDTH = 16. Required: exact match, order preserved, no dropped or duplicated tags.
